// File: rtl/rastreador_setor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rastreador_setor
//  Purpose  : Turns the signed pendulum position (step/16) into a confirmed
//             sector index 0..NUM_SETORES-1, or code 7 when the pendulum is
//             outside the travel range.  A hysteresis band around the
//             committed sector and a dwell filter keep setor_atual steady
//             enough for scoring and the LED/UI logic.
//  Ports    : clock            - system clock
//             reset            - synchronous, active-high reset
//             current_position - signed pendulum position, step/16
//             setor_atual      - last committed in-range sector (held while
//                                the committed code is out of range)
//             setor_valido     - committed code is an in-range sector
//             fora_faixa       - committed code is "out of range" (7)
//             setor_mudou      - one-cycle pulse on a commit that changes
//                                the committed code
//  Revision : 1.0 - initial release
// ============================================================================
module rastreador_setor #(
    parameter int TOTAL_RANGE_STEPS16 = 3200,
    parameter int NUM_SETORES         = 5,
    parameter int HYST_STEPS16        = 32,
    parameter int DWELL_CYCLES        = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] current_position,
    output logic [2:0]  setor_atual,
    output logic        setor_valido,
    output logic        fora_faixa,
    output logic        setor_mudou
);

    // Sector width in step/16; NUM_SETORES must divide the range for the
    // sectors to tile it exactly (any remainder is folded into the last one).
    localparam int             SETOR     = TOTAL_RANGE_STEPS16 / NUM_SETORES;
    localparam int             CNT_W     = $clog2(DWELL_CYCLES + 1);
    localparam logic [2:0]     CODE_FORA = 3'd7;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        ESTAVEL  = 1'b0,
        CONFIRMA = 1'b1
    } estado_t;

    // Edge constants are evaluated at elaboration time and narrowed to the
    // 17-bit signed domain, which comfortably holds k*S-H below zero and
    // (k+1)*S+H above the range for any 16-bit position.
    function automatic logic signed [16:0] edge17(input int value);
        return 17'(value);
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: position register (no reset needed; it is plain data)
    // ------------------------------------------------------------------
    logic signed [15:0] pos_r;
    logic signed [16:0] pos_ext;

    always_ff @(posedge clock) begin
        pos_r <= current_position;
    end

    assign pos_ext = {pos_r[15], pos_r};

    // ------------------------------------------------------------------
    // Raw sector code: unrolled constant compares, no divider.  The loop
    // keeps the highest sector whose lower edge the position has passed.
    // ------------------------------------------------------------------
    logic [2:0] raw_code;

    always_comb begin
        raw_code = CODE_FORA;
        if ((pos_ext >= 17'sd0) && (pos_ext < edge17(TOTAL_RANGE_STEPS16))) begin
            raw_code = 3'd0;
            for (int k = 1; k < NUM_SETORES; k++) begin
                if (pos_ext >= edge17(k * SETOR)) begin
                    raw_code = 3'(k);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Leaving detection relative to the committed code.  For an in-range
    // committed sector the window is widened by the hysteresis band on
    // both sides; for the out-of-range code any in-range raw code leaves.
    // ------------------------------------------------------------------
    logic [2:0] committed;
    logic       leaving;

    always_comb begin
        leaving = (raw_code != CODE_FORA);
        for (int k = 0; k < NUM_SETORES; k++) begin
            if (committed == 3'(k)) begin
                leaving = (pos_ext <  edge17(k * SETOR - HYST_STEPS16)) ||
                          (pos_ext >= edge17((k + 1) * SETOR + HYST_STEPS16));
            end
        end
    end

    // ------------------------------------------------------------------
    // Dwell FSM: state register
    // ------------------------------------------------------------------
    estado_t          state;
    estado_t          state_next;
    logic [2:0]       cand;
    logic [2:0]       cand_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       committed_next;
    logic [2:0]       atual_next;
    logic             valido_next;
    logic             fora_next;
    logic             mudou_next;
    logic             commit;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ESTAVEL;
            cand         <= CODE_FORA;
            cnt          <= '0;
            committed    <= CODE_FORA;
            setor_atual  <= 3'd0;
            setor_valido <= 1'b0;
            fora_faixa   <= 1'b0;
            setor_mudou  <= 1'b0;
        end else begin
            state        <= state_next;
            cand         <= cand_next;
            cnt          <= cnt_next;
            committed    <= committed_next;
            setor_atual  <= atual_next;
            setor_valido <= valido_next;
            fora_faixa   <= fora_next;
            setor_mudou  <= mudou_next;
        end
    end

    // ------------------------------------------------------------------
    // Dwell FSM: next state.  cnt holds how many consecutive cycles the
    // candidate has been seen; the DWELL_CYCLES-th matching cycle commits.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            ESTAVEL: begin
                if (leaving) begin
                    cand_next  = raw_code;
                    cnt_next   = CNT_ONE;
                    state_next = CONFIRMA;
                end
            end
            CONFIRMA: begin
                if (raw_code == cand) begin
                    if (cnt == CNT_LIMIT) begin
                        commit     = 1'b1;
                        cnt_next   = '0;
                        state_next = ESTAVEL;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end else if (leaving) begin
                    // Still outside the committed window but somewhere else:
                    // start confirming the new candidate from scratch.
                    cand_next = raw_code;
                    cnt_next  = CNT_ONE;
                end else begin
                    // Came back inside the committed window: drop candidate.
                    cnt_next   = '0;
                    state_next = ESTAVEL;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = ESTAVEL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Commit path: all outputs are registered and move on the same edge.
    // setor_atual keeps the last in-range sector when code 7 is committed.
    // ------------------------------------------------------------------
    always_comb begin
        committed_next = committed;
        atual_next     = setor_atual;
        valido_next    = setor_valido;
        fora_next      = fora_faixa;
        mudou_next     = 1'b0;
        if (commit) begin
            committed_next = cand;
            valido_next    = (cand != CODE_FORA);
            fora_next      = (cand == CODE_FORA);
            mudou_next     = (cand != committed);
            if (cand != CODE_FORA) begin
                atual_next = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rastreador_setor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_rastreador_setor
//  Purpose  : Self-checking bench for rastreador_setor (DWELL_CYCLES=4,
//             S=640, H=32).  A behavioural model derives the sector by
//             division and tracks the run of identical raw codes; outputs
//             are compared every cycle, and directed scenarios pin the
//             latencies and hysteresis behaviour with literal values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rastreador_setor;

    localparam int TOTAL = 3200;
    localparam int NUM   = 5;
    localparam int HYST  = 32;
    localparam int DWELL = 4;
    localparam int S     = TOTAL / NUM;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] current_position = 16'd700;
    logic [2:0]  setor_atual;
    logic        setor_valido;
    logic        fora_faixa;
    logic        setor_mudou;

    rastreador_setor #(
        .TOTAL_RANGE_STEPS16 (TOTAL),
        .NUM_SETORES         (NUM),
        .HYST_STEPS16        (HYST),
        .DWELL_CYCLES        (DWELL)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .current_position (current_position),
        .setor_atual      (setor_atual),
        .setor_valido     (setor_valido),
        .fora_faixa       (fora_faixa),
        .setor_mudou      (setor_mudou)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int m_pos       = 0;
    int m_committed = 7;
    int m_atual     = 0;
    int m_valido    = 0;
    int m_fora      = 0;
    int m_mudou     = 0;
    int run_code    = 7;
    int run_len     = 0;
    bit m_ready     = 1'b0;

    function automatic int code_of(input int p);
        if (p < 0 || p >= TOTAL) return 7;
        if (p / S >= NUM) return NUM - 1;
        return p / S;
    endfunction

    function automatic bit outside(input int p, input int c);
        if (c == 7) return code_of(p) != 7;
        return (p < c * S - HYST) || (p >= (c + 1) * S + HYST);
    endfunction

    always @(posedge clock) begin
        int raw;
        int len;
        int code;
        int comm;
        int atual;
        int valido;
        int fora;
        int mudou;
        if (reset) begin
            m_committed <= 7;
            m_atual     <= 0;
            m_valido    <= 0;
            m_fora      <= 0;
            m_mudou     <= 0;
            run_code    <= 7;
            run_len     <= 0;
            m_ready     <= 1'b1;
        end else begin
            raw    = code_of(m_pos);
            code   = run_code;
            len    = run_len;
            comm   = m_committed;
            atual  = m_atual;
            valido = m_valido;
            fora   = m_fora;
            mudou  = 0;
            if (len > 0 && raw == code) begin
                len = len + 1;
            end else if (outside(m_pos, comm)) begin
                code = raw;
                len  = 1;
            end else begin
                len = 0;
            end
            if (len == DWELL) begin
                mudou  = (code != comm) ? 1 : 0;
                if (code != 7) atual = code;
                valido = (code != 7) ? 1 : 0;
                fora   = (code == 7) ? 1 : 0;
                comm   = code;
                len    = 0;
            end
            m_committed <= comm;
            m_atual     <= atual;
            m_valido    <= valido;
            m_fora      <= fora;
            m_mudou     <= mudou;
            run_code    <= code;
            run_len     <= len;
        end
        m_pos <= int'($signed(current_position));
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: wait for the falling edge and compare against the model.
    task automatic tick();
        @(negedge clock);
        if (m_ready) begin
            chk("model_setor_atual",  int'(setor_atual),  m_atual);
            chk("model_setor_valido", int'(setor_valido), m_valido);
            chk("model_fora_faixa",   int'(fora_faixa),   m_fora);
            chk("model_setor_mudou",  int'(setor_mudou),  m_mudou);
        end
    endtask

    task automatic set_pos(input int p);
        current_position = 16'(p);
    endtask

    task automatic wait_pulse(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!setor_mudou && n < limit);
    endtask

    task automatic hold(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            tick();
            if (setor_mudou) pulses++;
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;
        int p;

        // 1: reset, then hold 700 -> sector 1 after 4 cycles, one pulse
        reset = 1'b1;
        set_pos(700);
        tick();
        tick();
        chk("rst_atual",  int'(setor_atual),  0);
        chk("rst_valido", int'(setor_valido), 0);
        chk("rst_fora",   int'(fora_faixa),   0);
        chk("rst_mudou",  int'(setor_mudou),  0);
        reset = 1'b0;
        wait_pulse(10, n);
        chk("t1_latency", n, 4);
        chk("t1_atual",   int'(setor_atual),  1);
        chk("t1_valido",  int'(setor_valido), 1);
        chk("t1_fora",    int'(fora_faixa),   0);
        tick();
        chk("t1_pulse_width", int'(setor_mudou), 0);

        // 2: inside hysteresis no change; just past it -> sector 2
        set_pos(1300);
        hold(10, p);
        chk("t2_hyst_pulses", p, 0);
        chk("t2_hyst_atual",  int'(setor_atual), 1);
        set_pos(1320);
        wait_pulse(12, n);
        chk("t2_latency", n, 5);
        chk("t2_atual",   int'(setor_atual), 2);
        hold(3, p);
        chk("t2_extra_pulses", p, 0);

        // back to sector 1
        set_pos(700);
        wait_pulse(12, n);
        chk("back_latency", n, 5);
        chk("back_atual",   int'(setor_atual), 1);

        // 3: short excursion to 2000 aborts
        set_pos(2000);
        tick();
        tick();
        set_pos(700);
        hold(10, p);
        chk("t3_pulses", p, 0);
        chk("t3_atual",  int'(setor_atual), 1);

        // 4: negative position -> out of range, setor_atual held
        set_pos(-10);
        wait_pulse(12, n);
        chk("t4_latency", n, 5);
        chk("t4_valido",  int'(setor_valido), 0);
        chk("t4_fora",    int'(fora_faixa),   1);
        chk("t4_atual",   int'(setor_atual),  1);
        set_pos(3200);
        hold(8, p);
        chk("t4_top_pulses", p, 0);
        chk("t4_top_fora",   int'(fora_faixa), 1);

        // 5: 2000 briefly then 2600 -> commit 4, never 3
        set_pos(2000);
        tick();
        tick();
        set_pos(2600);
        wait_pulse(12, n);
        chk("t5_latency", n, 5);
        chk("t5_atual",   int'(setor_atual),  4);
        chk("t5_valido",  int'(setor_valido), 1);

        // 6: reset during CONFIRMA
        set_pos(700);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("t6_atual",  int'(setor_atual),  0);
        chk("t6_valido", int'(setor_valido), 0);
        chk("t6_fora",   int'(fora_faixa),   0);
        chk("t6_mudou",  int'(setor_mudou),  0);
        reset = 1'b0;
        wait_pulse(10, n);
        chk("t6_recover_latency", n, 4);
        chk("t6_recover_atual",   int'(setor_atual), 1);

        // Randomized segments: edge-biased positions, random hold lengths,
        // occasional resets; the model is compared every cycle.
        for (int seg = 0; seg < 400; seg++) begin
            int sel;
            int pos;
            sel = int'($urandom_range(0, 9));
            if (sel < 4) begin
                pos = int'($urandom_range(0, 3600)) - 200;
            end else if (sel < 8) begin
                pos = int'($urandom_range(0, NUM)) * S
                    + int'($urandom_range(0, 2 * HYST + 16)) - HYST - 8;
            end else if (sel == 8) begin
                pos = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
            end else begin
                pos = int'($urandom_range(0, 65535)) - 32768;
            end
            set_pos(pos);
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            repeat (int'($urandom_range(1, 7))) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
